// File: rtl/decode_if.sv
// Fetch/execute/writeback signal bundle for the RV32I decode stage.
// The slave side is the decode stage; the master side is its surroundings.
interface decode_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       instr;
  logic [XLEN-1:0]   pc;
  logic              flush;
  logic              wb_en;
  logic [REG_AW-1:0] wb_rd;
  logic [XLEN-1:0]   wb_data;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_pc;
  logic [XLEN-1:0]   out_rs1_val;
  logic [XLEN-1:0]   out_rs2_val;
  logic [REG_AW-1:0] out_rs1_idx;
  logic [REG_AW-1:0] out_rs2_idx;
  logic [REG_AW-1:0] out_rd;
  logic [XLEN-1:0]   out_imm;
  logic [2:0]        out_fmt;

  modport slave (
    input  in_valid, instr, pc, flush, wb_en, wb_rd, wb_data, out_ready,
    output in_ready, out_valid, out_pc, out_rs1_val, out_rs2_val,
           out_rs1_idx, out_rs2_idx, out_rd, out_imm, out_fmt
  );

  modport master (
    output in_valid, instr, pc, flush, wb_en, wb_rd, wb_data, out_ready,
    input  in_ready, out_valid, out_pc, out_rs1_val, out_rs2_val,
           out_rs1_idx, out_rs2_idx, out_rd, out_imm, out_fmt
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: register file, immediate generation and a one-deep
// output register behind a valid/ready handshake with flush and operand refresh.
module decode_stage #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int REG_AW = $clog2(NREGS),
  parameter int BYPASS = 1
) (
  input logic     clk,
  input logic     rst_n,
  decode_if.slave bus
);

  logic [6:0]        opcode;
  logic [4:0]        rs1_raw;
  logic [4:0]        rs2_raw;
  logic [4:0]        rd_raw;
  logic              in_ready;
  logic              accept;
  logic              wb_write;
  logic [XLEN-1:0]   imm;
  logic [2:0]        fmt;
  logic [XLEN-1:0]   rs1_rd_val;
  logic [XLEN-1:0]   rs2_rd_val;

  logic [XLEN-1:0]   regs_q [NREGS];
  logic [XLEN-1:0]   regs_d [NREGS];

  logic              out_valid_q,   out_valid_d;
  logic [XLEN-1:0]   out_pc_q,      out_pc_d;
  logic [XLEN-1:0]   out_rs1_val_q, out_rs1_val_d;
  logic [XLEN-1:0]   out_rs2_val_q, out_rs2_val_d;
  logic [REG_AW-1:0] out_rs1_idx_q, out_rs1_idx_d;
  logic [REG_AW-1:0] out_rs2_idx_q, out_rs2_idx_d;
  logic [REG_AW-1:0] out_rd_q,      out_rd_d;
  logic [XLEN-1:0]   out_imm_q,     out_imm_d;
  logic [2:0]        out_fmt_q,     out_fmt_d;

  assign opcode  = bus.instr[6:0];
  assign rs1_raw = bus.instr[19:15];
  assign rs2_raw = bus.instr[24:20];
  assign rd_raw  = bus.instr[11:7];

  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready && !bus.flush;
  // Out-of-range indices (non-power-of-two NREGS) never write.
  assign wb_write = bus.wb_en && (bus.wb_rd != '0) && (int'(bus.wb_rd) < NREGS);

  function automatic logic [XLEN-1:0] read_reg(
    input logic [4:0]        idx,
    input logic              wb_en,
    input logic [REG_AW-1:0] wb_rd,
    input logic [XLEN-1:0]   wb_data
  );
    logic [XLEN-1:0] v;
    v = '0;
    if (idx != 5'd0 && int'(idx) < NREGS) begin
      v = regs_q[REG_AW'(idx)];
      if (BYPASS != 0 && wb_en && int'(wb_rd) == int'(idx)) v = wb_data;
    end
    return v;
  endfunction

  assign rs1_rd_val = read_reg(rs1_raw, bus.wb_en, bus.wb_rd, bus.wb_data);
  assign rs2_rd_val = read_reg(rs2_raw, bus.wb_en, bus.wb_rd, bus.wb_data);

  // Sign fill first, then overwrite the low bits with the format's layout.
  always_comb begin
    imm = '0;
    fmt = 3'd0;
    case (opcode)
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
        imm        = {XLEN{bus.instr[31]}};
        imm[11:0]  = bus.instr[31:20];
        fmt        = 3'd1;
      end
      7'b0100011: begin
        imm        = {XLEN{bus.instr[31]}};
        imm[11:0]  = {bus.instr[31:25], bus.instr[11:7]};
        fmt        = 3'd2;
      end
      7'b1100011: begin
        imm        = {XLEN{bus.instr[31]}};
        imm[12:0]  = {bus.instr[31], bus.instr[7], bus.instr[30:25], bus.instr[11:8], 1'b0};
        fmt        = 3'd3;
      end
      7'b0110111, 7'b0010111: begin
        imm        = {XLEN{bus.instr[31]}};
        imm[31:0]  = {bus.instr[31:12], 12'b0};
        fmt        = 3'd4;
      end
      7'b1101111: begin
        imm        = {XLEN{bus.instr[31]}};
        imm[20:0]  = {bus.instr[31], bus.instr[19:12], bus.instr[20], bus.instr[30:21], 1'b0};
        fmt        = 3'd5;
      end
      default: begin
        imm = '0;
        fmt = 3'd0;
      end
    endcase
  end

  always_comb begin
    regs_d = regs_q;
    if (wb_write) regs_d[bus.wb_rd] = bus.wb_data;
  end

  always_comb begin
    out_valid_d   = out_valid_q;
    out_pc_d      = out_pc_q;
    out_rs1_val_d = out_rs1_val_q;
    out_rs2_val_d = out_rs2_val_q;
    out_rs1_idx_d = out_rs1_idx_q;
    out_rs2_idx_d = out_rs2_idx_q;
    out_rd_d      = out_rd_q;
    out_imm_d     = out_imm_q;
    out_fmt_d     = out_fmt_q;

    if (bus.flush)          out_valid_d = 1'b0;
    else if (accept)        out_valid_d = 1'b1;
    else if (bus.out_ready) out_valid_d = 1'b0;

    if (accept) begin
      out_pc_d      = bus.pc;
      out_rs1_val_d = rs1_rd_val;
      out_rs2_val_d = rs2_rd_val;
      out_rs1_idx_d = REG_AW'(rs1_raw);
      out_rs2_idx_d = REG_AW'(rs2_raw);
      out_rd_d      = REG_AW'(rd_raw);
      out_imm_d     = imm;
      out_fmt_d     = fmt;
    end else if (out_valid_q && wb_write) begin
      // A held bundle tracks writebacks so execute never sees stale operands.
      if (bus.wb_rd == out_rs1_idx_q) out_rs1_val_d = bus.wb_data;
      if (bus.wb_rd == out_rs2_idx_q) out_rs2_val_d = bus.wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      out_valid_q   <= 1'b0;
      out_pc_q      <= '0;
      out_rs1_val_q <= '0;
      out_rs2_val_q <= '0;
      out_rs1_idx_q <= '0;
      out_rs2_idx_q <= '0;
      out_rd_q      <= '0;
      out_imm_q     <= '0;
      out_fmt_q     <= '0;
    end else begin
      regs_q        <= regs_d;
      out_valid_q   <= out_valid_d;
      out_pc_q      <= out_pc_d;
      out_rs1_val_q <= out_rs1_val_d;
      out_rs2_val_q <= out_rs2_val_d;
      out_rs1_idx_q <= out_rs1_idx_d;
      out_rs2_idx_q <= out_rs2_idx_d;
      out_rd_q      <= out_rd_d;
      out_imm_q     <= out_imm_d;
      out_fmt_q     <= out_fmt_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_pc      = out_pc_q;
  assign bus.out_rs1_val = out_rs1_val_q;
  assign bus.out_rs2_val = out_rs2_val_q;
  assign bus.out_rs1_idx = out_rs1_idx_q;
  assign bus.out_rs2_idx = out_rs2_idx_q;
  assign bus.out_rd      = out_rd_q;
  assign bus.out_imm     = out_imm_q;
  assign bus.out_fmt     = out_fmt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage; a BYPASS=0 copy shares every input with
// the BYPASS=1 instance so forwarding can be compared side by side.
module tb_decode_stage;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  decode_if #(.XLEN(32), .REG_AW(5)) bus ();
  decode_if #(.XLEN(32), .REG_AW(5)) bus0 ();

  decode_stage #(.XLEN(32), .NREGS(32), .REG_AW(5), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );
  decode_stage #(.XLEN(32), .NREGS(32), .REG_AW(5), .BYPASS(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave)
  );

  assign bus0.in_valid  = bus.in_valid;
  assign bus0.instr     = bus.instr;
  assign bus0.pc        = bus.pc;
  assign bus0.flush     = bus.flush;
  assign bus0.wb_en     = bus.wb_en;
  assign bus0.wb_rd     = bus.wb_rd;
  assign bus0.wb_data   = bus.wb_data;
  assign bus0.out_ready = bus.out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_wb(input logic [4:0] rd, input logic [31:0] d);
    bus.wb_en = 1'b1; bus.wb_rd = rd; bus.wb_data = d;
    tick();
    bus.wb_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 0; bus.instr = 0; bus.pc = 0; bus.flush = 0;
    bus.wb_en = 0; bus.wb_rd = 0; bus.wb_data = 0; bus.out_ready = 1;
    tick(); tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.out_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", bus.out_pc); end
    total++; if (bus.out_imm !== 32'h0) begin bad++; $display("FAIL reset_imm got=%h exp=0", bus.out_imm); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_addi();
    do_wb(5'd5, 32'hDEADBEEF);
    bus.in_valid = 1; bus.instr = 32'hFFF28093; bus.pc = 32'h100;
    tick();
    bus.in_valid = 0;
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL addi_valid got=%b exp=1", bus.out_valid); end
    total++; if (bus.out_rs1_val !== 32'hDEADBEEF) begin bad++; $display("FAIL addi_rs1 got=%h exp=deadbeef", bus.out_rs1_val); end
    total++; if (bus.out_imm !== 32'hFFFFFFFF) begin bad++; $display("FAIL addi_imm got=%h exp=ffffffff", bus.out_imm); end
    total++; if (bus.out_fmt !== 3'd1) begin bad++; $display("FAIL addi_fmt got=%0d exp=1", bus.out_fmt); end
    total++; if (bus.out_rd !== 5'd1) begin bad++; $display("FAIL addi_rd got=%0d exp=1", bus.out_rd); end
    total++; if (bus.out_rs1_idx !== 5'd5) begin bad++; $display("FAIL addi_rs1_idx got=%0d exp=5", bus.out_rs1_idx); end
    total++; if (bus.out_pc !== 32'h100) begin bad++; $display("FAIL addi_pc got=%h exp=100", bus.out_pc); end
    tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL drain_valid got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_formats();
    logic [31:0] ins [5];
    logic [31:0] eimm [5];
    logic [2:0]  efmt [5];
    logic [4:0]  erd [5];
    ins  = '{32'hFE112E23, 32'hFE000EE3, 32'h123450B7, 32'hFF5FF0EF, 32'h00018233};
    eimm = '{32'hFFFFFFFC, 32'hFFFFFFFC, 32'h12345000, 32'hFFFFFFF4, 32'h00000000};
    efmt = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
    erd  = '{5'd28, 5'd29, 5'd1, 5'd1, 5'd4};
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 1; bus.instr = ins[k]; bus.pc = 32'h180 + 32'(4 * k);
      tick();
      total++; if (bus.out_imm !== eimm[k]) begin bad++; $display("FAIL fmt_imm[%0d] got=%h exp=%h", k, bus.out_imm, eimm[k]); end
      total++; if (bus.out_fmt !== efmt[k]) begin bad++; $display("FAIL fmt_fmt[%0d] got=%0d exp=%0d", k, bus.out_fmt, efmt[k]); end
      total++; if (bus.out_rd !== erd[k]) begin bad++; $display("FAIL fmt_rd[%0d] got=%0d exp=%0d", k, bus.out_rd, erd[k]); end
    end
    bus.in_valid = 0;
    tick();
  endtask

  task automatic test_bypass();
    do_wb(5'd3, 32'h11);
    bus.wb_en = 1; bus.wb_rd = 5'd3; bus.wb_data = 32'h55;
    bus.in_valid = 1; bus.instr = 32'h00018233; bus.pc = 32'h200;
    tick();
    bus.wb_en = 0; bus.in_valid = 0;
    total++; if (bus.out_rs1_val !== 32'h55) begin bad++; $display("FAIL bypass1_rs1 got=%h exp=55", bus.out_rs1_val); end
    total++; if (bus0.out_rs1_val !== 32'h11) begin bad++; $display("FAIL bypass0_rs1 got=%h exp=11", bus0.out_rs1_val); end
    total++; if (bus.out_rs2_val !== 32'h0) begin bad++; $display("FAIL bypass_rs2_x0 got=%h exp=0", bus.out_rs2_val); end
    tick();
  endtask

  task automatic test_stall();
    bus.out_ready = 1;
    bus.in_valid = 1; bus.instr = 32'h00618233; bus.pc = 32'h300;
    tick();
    bus.out_ready = 0;
    bus.instr = 32'hFFF28093; bus.pc = 32'h400;
    #1;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready got=%b exp=0", bus.in_ready); end
    for (int c = 0; c < 3; c++) begin
      bus.wb_en = (c < 2); bus.wb_rd = (c == 0) ? 5'd3 : 5'd6; bus.wb_data = (c == 0) ? 32'h77 : 32'h88;
      tick();
      total++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h300) begin bad++; $display("FAIL stall_hold[%0d] got=%b/%h exp=1/300", c, bus.out_valid, bus.out_pc); end
      total++; if (bus.out_rs1_val !== 32'h77) begin bad++; $display("FAIL stall_rs1[%0d] got=%h exp=77", c, bus.out_rs1_val); end
      total++; if (bus.out_imm !== 32'h0 || bus.out_rd !== 5'd4) begin bad++; $display("FAIL stall_stable[%0d] got=%h/%0d exp=0/4", c, bus.out_imm, bus.out_rd); end
    end
    bus.wb_en = 0;
    total++; if (bus.out_rs2_val !== 32'h88) begin bad++; $display("FAIL stall_rs2 got=%h exp=88", bus.out_rs2_val); end
    total++; if (bus0.out_rs1_val !== 32'h77) begin bad++; $display("FAIL stall_rs1_nobypass got=%h exp=77", bus0.out_rs1_val); end
  endtask

  task automatic test_flush();
    bus.flush = 1; bus.in_valid = 1;
    #1;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL flush_stall_in_ready got=%b exp=0", bus.in_ready); end
    tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", bus.out_valid); end
    bus.out_ready = 1; bus.pc = 32'h500;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready got=%b exp=1", bus.in_ready); end
    tick();
    bus.flush = 0; bus.in_valid = 0;
    total++; if (bus.out_valid !== 1'b0 || bus.out_pc !== 32'h300) begin bad++; $display("FAIL flush_no_accept got=%b/%h exp=0/300", bus.out_valid, bus.out_pc); end
    do_wb(5'd0, 32'h1);
    bus.wb_en = 1; bus.wb_rd = 5'd0; bus.wb_data = 32'h1;
    bus.in_valid = 1; bus.instr = 32'h00000093; bus.pc = 32'h600;
    tick();
    bus.wb_en = 0; bus.in_valid = 0;
    total++; if (bus.out_rs1_val !== 32'h0) begin bad++; $display("FAIL x0_read got=%h exp=0", bus.out_rs1_val); end
    total++; if (bus0.out_rs1_val !== 32'h0) begin bad++; $display("FAIL x0_read_nobypass got=%h exp=0", bus0.out_rs1_val); end
    tick();
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1;
    for (int k = 0; k < 6; k++) begin
      bus.in_valid = 1; bus.pc = 32'h1000 + 32'(4 * k);
      bus.instr = {12'(k + 1), 5'd5, 3'b000, 5'd1, 7'b0010011};
      tick();
      total++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h1000 + 32'(4 * k)) begin bad++; $display("FAIL b2b_pc[%0d] got=%b/%h exp=1/%h", k, bus.out_valid, bus.out_pc, 32'h1000 + 32'(4 * k)); end
      total++; if (bus.out_imm !== 32'(k + 1)) begin bad++; $display("FAIL b2b_imm[%0d] got=%h exp=%h", k, bus.out_imm, 32'(k + 1)); end
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready[%0d] got=%b exp=1", k, bus.in_ready); end
    end
    #2;
    rst_n = 0;
    #1;
    total++; if (bus.out_valid !== 1'b0 || bus.out_pc !== 32'h0) begin bad++; $display("FAIL midreset got=%b/%h exp=0/0", bus.out_valid, bus.out_pc); end
    total++; if (bus.out_rs1_val !== 32'h0 || bus.out_imm !== 32'h0) begin bad++; $display("FAIL midreset_ops got=%h/%h exp=0/0", bus.out_rs1_val, bus.out_imm); end
    bus.in_valid = 0;
    tick();
    rst_n = 1;
    bus.in_valid = 1; bus.instr = 32'hFFF28093; bus.pc = 32'h700;
    tick();
    bus.in_valid = 0;
    total++; if (bus.out_rs1_val !== 32'h0) begin bad++; $display("FAIL regfile_cleared got=%h exp=0", bus.out_rs1_val); end
    total++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h700) begin bad++; $display("FAIL post_reset_accept got=%b/%h exp=1/700", bus.out_valid, bus.out_pc); end
    tick();
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_addi();
    test_formats();
    test_bypass();
    test_stall();
    test_flush();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
